stage_id: RTL
=============

Name: stage_id

Overview:
- Instruction-decode stage of the 5-stage RV32I pipeline, directly downstream of stage_IF.
- Takes the synchronous IMEM read data and selects the instruction for decode (bubble, replayed or fresh). Decodes control, generates immediates and reads the register file, which is written by WB.
- Detects load-use hazards and drives stall back to IF.
- Registers everything into the ID/EX pipeline register consumed by stage_EX.

Parameters:
- XLEN, 32, datapath width.
- NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- im_rdata  in  32  IMEM data for the PC presented by IF last cycle
- pc_in  in  32  pc_toID from IF
- pc4_in  in  32  pc4_toID from IF
- br_take  in  1  branch/jump taken from EX; flush
- wb_we  in  1  WB register write enable
- wb_rd  in  5  WB destination register
- wb_data  in  32  WB write data
- stall  out  1  load-use stall to IF (combinational)
- ex_pc, ex_pc4  out  32  registered PC / PC+4
- ex_rs1_data, ex_rs2_data  out  32  registered operands
- ex_imm  out  32  registered sign-extended immediate
- ex_rs1, ex_rs2, ex_rd  out  5  register indices, for forwarding
- ex_funct3  out  3  branch/load/store width
- ex_alu_op  out  4  alu_op_e
- ex_src_a_pc  out  1  ALU A = PC (AUIPC, JAL, branch target)
- ex_src_b_imm  out  1  ALU B = imm
- ex_mem_read, ex_mem_write, ex_reg_write, ex_branch, ex_jump  out  1  control bits
- ex_wb_sel  out  2  wb_sel_e: ALU / MEM / PC4
- ex_illegal  out  1  unsupported opcode seen

Behaviour:
- Reset: all ex_* outputs 0; flush_q=0; stall_q=1; last_inst=NOP_INSTR; every register file entry 0.
- flush_q<=br_take, stall_q<=stall, last_inst<=inst every cycle.
- Instruction select, priority order: inst = flush_q ? NOP_INSTR : stall_q ? last_inst : im_rdata.
  - The first cycle after reset decodes NOP.
- Decode covers LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM and OP.
  - Immediates use I/S/B/U/J formats, sign-extended to XLEN.
  - Any other opcode gives all-zero control with ex_illegal=1. Nothing else happens; EX ignores it.
- uses_rs1 is 0 for LUI, AUIPC and JAL. uses_rs2 is 1 only for BRANCH, STORE and OP.
- Register file:
  - 32x32, x0 reads 0, writes to x0 are ignored.
  - Two asynchronous reads, one write on posedge.
  - Write-first bypass: if wb_we, wb_rd!=0 and wb_rd==rsN in the same cycle, the read returns wb_data.
- Hazard: stall = ex_mem_read & (ex_rd!=0) & ((uses_rs1 & ex_rs1_idx==ex_rd) | (uses_rs2 & rs2==ex_rd)).
  - ex_rs1_idx / rs2 here are the indices of the instruction currently in ID.
  - stall is forced 0 when flush_q or br_take is high.
- ID/EX update on every posedge, priority rst > br_take > stall > normal:
  - br_take: load a bubble (all control 0, indices 0, data 0).
  - stall: load a bubble; the instruction in ID is kept via stall_q/last_inst replay while IF holds its PC.
  - normal: load the decoded values.
- Latency: one cycle from instruction select to ex_* outputs.
- Simultaneous br_take and stall: the flush wins, stall is deasserted, and the younger instruction is discarded.
- Simultaneous WB write and read of the same register: the bypass value is used.
- Reset asserted mid-operation: all state is cleared immediately (asynchronous), and decode resumes with NOP.

Decomposition:
- Package riscv_pkg holds:
  - opcode constants (OPC_LUI … OPC_OP)
  - alu_op_e (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASS_B)
  - wb_sel_e
  - imm_type_e
  - NOP_INSTR
- Sub-module reg_file holds the 32x32 array, two read ports, one write port and the bypass. It will be reused for verification-model checks.

Test Plan:
- Reset, then release with im_rdata=32'h0050_0093 (addi x1,x0,5). Cycle 1 shows ex_reg_write=0 (NOP). The next cycle shows ex_imm=5, ex_rd=1, ex_alu_op=ADD, ex_src_b_imm=1.
- wb_we=1, wb_rd=3, wb_data=32'hDEAD_BEEF in the same cycle that ID decodes add x4,x3,x0 -> ex_rs1_data=32'hDEAD_BEEF. A write to x0 followed by a read of x0 gives 0.
- lw x5,0(x2) then add x6,x5,x1 -> stall=1 for exactly one cycle, then a bubble in ID/EX. The add is replayed from last_inst and the next cycle shows ex_rs1=5.
- br_take=1 while ID holds sub -> the next ex_* is a bubble. The cycle after decodes NOP (flush_q) regardless of im_rdata.
- lw x5 in EX together with br_take=1 and a dependent instruction in ID -> stall=0 and a bubble is loaded.
- Instruction words: beq 32'hFE00_0EE3 gives ex_imm=32'hFFFF_FFFC with ex_branch=1. Opcode 7'h7F gives ex_illegal=1 with all control 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU/WB selectors, immediate formats
// and the control bundle carried from ID into EX.
package riscv_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_SLL    = 4'd2,
    ALU_SLT    = 4'd3,
    ALU_SLTU   = 4'd4,
    ALU_XOR    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_OR     = 4'd8,
    ALU_AND    = 4'd9,
    ALU_PASS_B = 4'd10
  } alu_op_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2
  } wb_sel_e;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_type_e;

  typedef struct packed {
    logic    illegal;
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    branch;
    logic    jump;
    logic    src_a_pc;
    logic    src_b_imm;
    wb_sel_e wb_sel;
    alu_op_e alu_op;
  } ctrl_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    ctrl_t       ctrl;
  } idex_t;

  function automatic logic [31:0] gen_imm(input logic [31:7] i, input imm_type_e t);
    logic [31:0] imm;
    case (t)
      IMM_I:   imm = {{20{i[31]}}, i[31:20]};
      IMM_S:   imm = {{20{i[31]}}, i[31:25], i[11:7]};
      IMM_B:   imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      IMM_U:   imm = {i[31:12], 12'h000};
      IMM_J:   imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: imm = 32'h0000_0000;
    endcase
    return imm;
  endfunction

  // SUB only exists for register-register ops; funct7[5] selects SRA in both forms.
  function automatic alu_op_e alu_from_funct(input logic [2:0] f3, input logic f7b5,
                                             input logic is_op);
    alu_op_e op;
    case (f3)
      3'b000:  op = (is_op && f7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = f7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      3'b111:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/reg_file.sv
// 32x32 integer register file: two asynchronous read ports with write-first
// bypass from the single write port; x0 is hardwired to zero.
module reg_file (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  raddr1_i,
  input  logic [4:0]  raddr2_i,
  output logic [31:0] rdata1_o,
  output logic [31:0] rdata2_o
);

  logic [31:0] mem_q [32];
  logic        wr_en_s;

  assign wr_en_s = we_i && (waddr_i != 5'd0);

  // Register array write; entry 0 is never written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        mem_q[i] <= 32'h0000_0000;
      end
    end else if (wr_en_s) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read ports see a same-cycle WB write before it lands in the array.
  always_comb begin
    rdata1_o = 32'h0000_0000;
    rdata2_o = 32'h0000_0000;
    if (raddr1_i == 5'd0) begin
      rdata1_o = 32'h0000_0000;
    end else if (wr_en_s && (waddr_i == raddr1_i)) begin
      rdata1_o = wdata_i;
    end else begin
      rdata1_o = mem_q[raddr1_i];
    end
    if (raddr2_i == 5'd0) begin
      rdata2_o = 32'h0000_0000;
    end else if (wr_en_s && (waddr_i == raddr2_i)) begin
      rdata2_o = wdata_i;
    end else begin
      rdata2_o = mem_q[raddr2_i];
    end
  end

endmodule

// File: rtl/stage_id.sv
// RV32I instruction-decode stage: instruction select/replay, control decode,
// immediate generation, register read, load-use stall and the ID/EX register.
module stage_id #(
  parameter int          XLEN      = 32,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     im_rdata,
  input  logic [XLEN-1:0] pc_in,
  input  logic [XLEN-1:0] pc4_in,
  input  logic            br_take,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            stall,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_pc4,
  output logic [XLEN-1:0] ex_rs1_data,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic [4:0]      ex_rd,
  output logic [2:0]      ex_funct3,
  output logic [3:0]      ex_alu_op,
  output logic            ex_src_a_pc,
  output logic            ex_src_b_imm,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            ex_reg_write,
  output logic            ex_branch,
  output logic            ex_jump,
  output logic [1:0]      ex_wb_sel,
  output logic            ex_illegal
);
  import riscv_pkg::*;

  logic        flush_q;
  logic        stall_q;
  logic [31:0] last_inst_q;
  logic [31:0] inst_s;
  logic [6:0]  opcode_s;
  logic [4:0]  rd_s;
  logic [4:0]  rs1_s;
  logic [4:0]  rs2_s;
  logic [2:0]  funct3_s;
  ctrl_t       ctrl_s;
  imm_type_e   imm_type_s;
  logic        uses_rs1_s;
  logic        uses_rs2_s;
  logic        stall_s;
  logic [31:0] rs1_data_s;
  logic [31:0] rs2_data_s;
  idex_t       idex_d;
  idex_t       idex_q;

  // A flushed slot decodes as NOP; a stalled instruction is replayed from last_inst_q.
  assign inst_s   = flush_q ? NOP_INSTR : (stall_q ? last_inst_q : im_rdata);
  assign opcode_s = inst_s[6:0];
  assign rd_s     = inst_s[11:7];
  assign funct3_s = inst_s[14:12];
  assign rs1_s    = inst_s[19:15];
  assign rs2_s    = inst_s[24:20];

  // Control decode; unknown opcodes leave all control cleared except illegal.
  always_comb begin
    ctrl_s        = '0;
    ctrl_s.alu_op = ALU_ADD;
    ctrl_s.wb_sel = WB_ALU;
    imm_type_s    = IMM_NONE;
    uses_rs1_s    = 1'b1;
    uses_rs2_s    = 1'b0;
    case (opcode_s)
      OPC_LUI: begin
        ctrl_s.reg_write = 1'b1; ctrl_s.src_b_imm = 1'b1; ctrl_s.alu_op = ALU_PASS_B;
        imm_type_s = IMM_U; uses_rs1_s = 1'b0;
      end
      OPC_AUIPC: begin
        ctrl_s.reg_write = 1'b1; ctrl_s.src_a_pc = 1'b1; ctrl_s.src_b_imm = 1'b1;
        imm_type_s = IMM_U; uses_rs1_s = 1'b0;
      end
      OPC_JAL: begin
        ctrl_s.reg_write = 1'b1; ctrl_s.jump = 1'b1; ctrl_s.src_a_pc = 1'b1;
        ctrl_s.src_b_imm = 1'b1; ctrl_s.wb_sel = WB_PC4;
        imm_type_s = IMM_J; uses_rs1_s = 1'b0;
      end
      OPC_JALR: begin
        ctrl_s.reg_write = 1'b1; ctrl_s.jump = 1'b1; ctrl_s.src_b_imm = 1'b1;
        ctrl_s.wb_sel = WB_PC4; imm_type_s = IMM_I;
      end
      OPC_BRANCH: begin
        ctrl_s.branch = 1'b1; ctrl_s.src_a_pc = 1'b1; ctrl_s.src_b_imm = 1'b1;
        imm_type_s = IMM_B; uses_rs2_s = 1'b1;
      end
      OPC_LOAD: begin
        ctrl_s.reg_write = 1'b1; ctrl_s.mem_read = 1'b1; ctrl_s.src_b_imm = 1'b1;
        ctrl_s.wb_sel = WB_MEM; imm_type_s = IMM_I;
      end
      OPC_STORE: begin
        ctrl_s.mem_write = 1'b1; ctrl_s.src_b_imm = 1'b1;
        imm_type_s = IMM_S; uses_rs2_s = 1'b1;
      end
      OPC_OP_IMM: begin
        ctrl_s.reg_write = 1'b1; ctrl_s.src_b_imm = 1'b1;
        ctrl_s.alu_op = alu_from_funct(funct3_s, inst_s[30], 1'b0);
        imm_type_s = IMM_I;
      end
      OPC_OP: begin
        ctrl_s.reg_write = 1'b1;
        ctrl_s.alu_op = alu_from_funct(funct3_s, inst_s[30], 1'b1);
        uses_rs2_s = 1'b1;
      end
      default: begin
        ctrl_s.illegal = 1'b1;
      end
    endcase
    // rd=x0 never writes back, so NOP reaches EX as a true bubble.
    ctrl_s.reg_write = ctrl_s.reg_write & (rd_s != 5'd0);
  end

  assign stall_s = idex_q.ctrl.mem_read && (idex_q.rd != 5'd0) && !flush_q && !br_take &&
                   ((uses_rs1_s && (rs1_s == idex_q.rd)) ||
                    (uses_rs2_s && (rs2_s == idex_q.rd)));
  assign stall   = stall_s;

  reg_file u_reg_file (
    .clk      (clk),
    .rst      (rst),
    .we_i     (wb_we),
    .waddr_i  (wb_rd),
    .wdata_i  (wb_data),
    .raddr1_i (rs1_s),
    .raddr2_i (rs2_s),
    .rdata1_o (rs1_data_s),
    .rdata2_o (rs2_data_s)
  );

  // ID/EX next state: flush or stall inserts an all-zero bubble.
  always_comb begin
    idex_d = '0;
    if (br_take || stall_s) begin
      idex_d = '0;
    end else begin
      idex_d.pc       = pc_in;
      idex_d.pc4      = pc4_in;
      idex_d.rs1_data = rs1_data_s;
      idex_d.rs2_data = rs2_data_s;
      idex_d.imm      = gen_imm(inst_s[31:7], imm_type_s);
      idex_d.rs1      = rs1_s;
      idex_d.rs2      = rs2_s;
      idex_d.rd       = rd_s;
      idex_d.funct3   = funct3_s;
      idex_d.ctrl     = ctrl_s;
    end
  end

  // Pipeline state; stall_q resets high so the first decode after reset is the NOP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush_q     <= 1'b0;
      stall_q     <= 1'b1;
      last_inst_q <= NOP_INSTR;
      idex_q      <= '0;
    end else begin
      flush_q     <= br_take;
      stall_q     <= stall_s;
      last_inst_q <= inst_s;
      idex_q      <= idex_d;
    end
  end

  assign ex_pc        = idex_q.pc;
  assign ex_pc4       = idex_q.pc4;
  assign ex_rs1_data  = idex_q.rs1_data;
  assign ex_rs2_data  = idex_q.rs2_data;
  assign ex_imm       = idex_q.imm;
  assign ex_rs1       = idex_q.rs1;
  assign ex_rs2       = idex_q.rs2;
  assign ex_rd        = idex_q.rd;
  assign ex_funct3    = idex_q.funct3;
  assign ex_alu_op    = idex_q.ctrl.alu_op;
  assign ex_src_a_pc  = idex_q.ctrl.src_a_pc;
  assign ex_src_b_imm = idex_q.ctrl.src_b_imm;
  assign ex_mem_read  = idex_q.ctrl.mem_read;
  assign ex_mem_write = idex_q.ctrl.mem_write;
  assign ex_reg_write = idex_q.ctrl.reg_write;
  assign ex_branch    = idex_q.ctrl.branch;
  assign ex_jump      = idex_q.ctrl.jump;
  assign ex_wb_sel    = idex_q.ctrl.wb_sel;
  assign ex_illegal   = idex_q.ctrl.illegal;

endmodule
